// File: rtl/move_query_scheduler_pkg.sv
// Shared map/scheduler definitions.
// Holds the default map geometry, the index widths used on the request bus,
// the bit positions of the move vector and the scheduler FSM encoding.
package move_query_scheduler_pkg;

  localparam int MAP_COLS = 80;
  localparam int MAP_ROWS = 60;
  localparam int IDX_X_W  = 7;
  localparam int IDX_Y_W  = 6;
  localparam int ID_W     = 2;
  localparam int MOVE_W   = 4;

  // Move vector bit positions: rsp_moves = {Left, Down, Up, Right}
  localparam int MV_RIGHT = 0;
  localparam int MV_UP    = 1;
  localparam int MV_DOWN  = 2;
  localparam int MV_LEFT  = 3;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_RESP  = 2'd2;

  // Query latched at grant time; later index changes on the bus are ignored.
  typedef struct packed {
    logic [IDX_X_W-1:0] x;
    logic [IDX_Y_W-1:0] y;
    logic [ID_W-1:0]    id;
  } query_t;

endpackage

// File: rtl/move_query_scheduler_if.sv
// Request/response and map-memory bus of the move query scheduler.
//   req, req_idx_x, req_idx_y : per-requester level request and packed indices
//   gnt                       : one-hot accept pulse
//   mem_en, mem_addr, mem_dout: read port of the external map row memory
//   rsp_valid, rsp_id, rsp_moves : result pulse, requester id, {L,D,U,R}
//   busy                      : a query is in flight
// master = requesters + memory side, slave = scheduler.
interface move_query_scheduler_if #(
  parameter int NUM_REQ  = 4,
  parameter int MAP_COLS = move_query_scheduler_pkg::MAP_COLS
);
  import move_query_scheduler_pkg::*;

  logic [NUM_REQ-1:0]         req;
  logic [NUM_REQ*IDX_X_W-1:0] req_idx_x;
  logic [NUM_REQ*IDX_Y_W-1:0] req_idx_y;
  logic [NUM_REQ-1:0]         gnt;
  logic                       mem_en;
  logic [IDX_Y_W-1:0]         mem_addr;
  logic [MAP_COLS-1:0]        mem_dout;
  logic                       rsp_valid;
  logic [ID_W-1:0]            rsp_id;
  logic [MOVE_W-1:0]          rsp_moves;
  logic                       busy;

  modport master (
    output req, req_idx_x, req_idx_y, mem_dout,
    input  gnt, mem_en, mem_addr, rsp_valid, rsp_id, rsp_moves, busy
  );

  modport slave (
    input  req, req_idx_x, req_idx_y, mem_dout,
    output gnt, mem_en, mem_addr, rsp_valid, rsp_id, rsp_moves, busy
  );

endinterface

// File: rtl/move_query_scheduler_rr_arbiter.sv
// Round-robin arbiter.
//   req    : request vector          mask  : requests excluded this cycle
//   accept : the grant is taken, advance the pointer past the winner
//   gnt    : one-hot winner          gnt_id: winner index   valid: any winner
// The search starts at ptr, which is the id after the last accepted winner.
module rr_arbiter
  import move_query_scheduler_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] mask,
  input  logic               accept,
  output logic [NUM_REQ-1:0] gnt,
  output logic [ID_W-1:0]    gnt_id,
  output logic               valid
);

  logic [ID_W-1:0]    ptr;
  logic [NUM_REQ-1:0] elig;

  assign elig = req & ~mask;

  always_comb begin
    gnt    = '0;
    gnt_id = '0;
    valid  = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!valid && elig[(int'(ptr) + i) % NUM_REQ]) begin
        valid                              = 1'b1;
        gnt[(int'(ptr) + i) % NUM_REQ]     = 1'b1;
        gnt_id                             = ID_W'((int'(ptr) + i) % NUM_REQ);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (accept && valid) begin
      ptr <= ID_W'((int'(gnt_id) + 1) % NUM_REQ);
    end
  end

endmodule

// File: rtl/move_query_scheduler.sv
// Move query scheduler: serialises requester queries onto the single map
// memory read port. Each query reads the rows above, at and below the
// requester's cell and answers with the legal moves {Left, Down, Up, Right}.
//   clk, rst : clock, synchronous active-high reset
//   bus      : request/response and memory bus (slave side)
// Timing: gnt at T, row reads at T+1..T+3, rsp_valid at T+4+READ_LAT.
module move_query_scheduler #(
  parameter int NUM_REQ  = 4,
  parameter int MAP_COLS = move_query_scheduler_pkg::MAP_COLS,
  parameter int MAP_ROWS = move_query_scheduler_pkg::MAP_ROWS,
  parameter int READ_LAT = 1
) (
  input logic                   clk,
  input logic                   rst,
  move_query_scheduler_if.slave bus
);
  import move_query_scheduler_pkg::*;

  localparam int CNT_W = $clog2(READ_LAT + 4);
  localparam int LAST  = 2 + READ_LAT;

  logic [1:0]         state;
  logic [CNT_W-1:0]   cnt;
  query_t             q;
  logic               above, same_l, same_r;
  logic [ID_W-1:0]    rsp_id_q;
  logic [MOVE_W-1:0]  rsp_moves_q;

  logic               arb_ok, arb_valid, take;
  logic [NUM_REQ-1:0] arb_gnt, arb_mask;
  logic [ID_W-1:0]    arb_id;
  logic [IDX_X_W-1:0] sel_x;
  logic [IDX_Y_W-1:0] sel_y;

  // Column bit of a map row; columns beyond the map read as wall.
  function automatic logic row_bit(input logic [MAP_COLS-1:0] row,
                                   input logic [IDX_X_W-1:0]  idx);
    if (int'(idx) < MAP_COLS) return row[idx];
    return 1'b0;
  endfunction

  // Horizontal edges wrap through the tunnel, vertical edges are closed.
  function automatic logic [MOVE_W-1:0] calc_moves(
    input logic [IDX_X_W-1:0] x, input logic [IDX_Y_W-1:0] y,
    input logic up_b, input logic left_b, input logic right_b, input logic down_b);
    logic [MOVE_W-1:0] m;
    m = '0;
    if (int'(x) < MAP_COLS && int'(y) < MAP_ROWS) begin
      m[MV_RIGHT] = (int'(x) == MAP_COLS - 1) ? 1'b1 : right_b;
      m[MV_LEFT]  = (x == 0) ? 1'b1 : left_b;
      m[MV_UP]    = (y == 0) ? 1'b0 : up_b;
      m[MV_DOWN]  = (int'(y) == MAP_ROWS - 1) ? 1'b0 : down_b;
    end
    return m;
  endfunction

  // Arbitration runs in IDLE and RESP; the id being answered is masked so a
  // requester still holding req through its own response is not regranted.
  assign arb_ok   = !rst && (state == ST_IDLE || state == ST_RESP);
  assign arb_mask = (state == ST_RESP) ? (NUM_REQ'(1) << q.id) : '0;
  assign take     = arb_ok && arb_valid;
  assign sel_x    = bus.req_idx_x[int'(arb_id)*IDX_X_W +: IDX_X_W];
  assign sel_y    = bus.req_idx_y[int'(arb_id)*IDX_Y_W +: IDX_Y_W];

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .clk    (clk),
    .rst    (rst),
    .req    (bus.req),
    .mask   (arb_mask),
    .accept (arb_ok),
    .gnt    (arb_gnt),
    .gnt_id (arb_id),
    .valid  (arb_valid)
  );

  assign bus.gnt       = arb_gnt & {NUM_REQ{arb_ok}};
  assign bus.rsp_valid = !rst && (state == ST_RESP);
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_moves = rsp_moves_q;
  assign bus.busy      = (state != ST_IDLE);

  // Row reads: above, same, below; clamped at the top and bottom rows.
  always_comb begin
    bus.mem_en   = 1'b0;
    bus.mem_addr = '0;
    if (!rst && state == ST_FETCH && cnt <= 2) begin
      bus.mem_en = 1'b1;
      case (cnt)
        CNT_W'(0): bus.mem_addr = (q.y == 0) ? '0 : q.y - 1'b1;
        CNT_W'(1): bus.mem_addr = q.y;
        default:   bus.mem_addr = (q.y == IDX_Y_W'(MAP_ROWS - 1)) ? q.y : q.y + 1'b1;
      endcase
    end
  end

  // Control: FSM, phase counter and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      rsp_id_q    <= '0;
      rsp_moves_q <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (take) begin
            state <= ST_FETCH;
            cnt   <= '0;
          end
        end
        ST_FETCH: begin
          cnt <= cnt + 1'b1;
          if (cnt == CNT_W'(LAST)) begin
            state       <= ST_RESP;
            rsp_id_q    <= q.id;
            // The below bit arrives this cycle and goes straight into the result.
            rsp_moves_q <= calc_moves(q.x, q.y, above, same_l, same_r,
                                      row_bit(bus.mem_dout, q.x));
          end
        end
        ST_RESP: begin
          if (take) begin
            state <= ST_FETCH;
            cnt   <= '0;
          end else begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Data: latched query and captured neighbour bits
  always_ff @(posedge clk) begin
    if (take) q <= '{x: sel_x, y: sel_y, id: arb_id};
    if (state == ST_FETCH && cnt == CNT_W'(READ_LAT)) begin
      above <= row_bit(bus.mem_dout, q.x);
    end
    if (state == ST_FETCH && cnt == CNT_W'(READ_LAT + 1)) begin
      same_l <= row_bit(bus.mem_dout, q.x - 1'b1);
      same_r <= row_bit(bus.mem_dout, q.x + 1'b1);
    end
  end

endmodule

// File: doc/move_query_scheduler.md
MOVE_QUERY_SCHEDULER -- requirements
Module: move_query_scheduler

Interface
REQ-001 Parameter NUM_REQ, default 4: number of requesters (id 0 = pacman, 1..3 = ghosts).
REQ-002 Parameter MAP_COLS, default 80: map row width in bits; column index range 0..MAP_COLS-1.
REQ-003 Parameter MAP_ROWS, default 60: number of map rows; row index range 0..MAP_ROWS-1.
REQ-004 Parameter READ_LAT, default 1: block-memory read latency in cycles, from address issue to data valid.
REQ-005 clk  input  1  sole clock; all logic on its rising edge.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 req  input  NUM_REQ  per-requester level request.
REQ-008 req_idx_x  input  NUM_REQ*7  packed map column index; slot i = bits [7i+6:7i].
REQ-009 req_idx_y  input  NUM_REQ*6  packed map row index; slot i = bits [6i+5:6i].
REQ-010 gnt  output  NUM_REQ  one-hot, one-cycle pulse: the query is accepted.
REQ-011 mem_en  output  1  map memory read enable.
REQ-012 mem_addr  output  6  map memory row address.
REQ-013 mem_dout  input  MAP_COLS  map row data; 1 = open/food, 0 = wall.
REQ-014 rsp_valid  output  1  one-cycle pulse: the result is valid.
REQ-015 rsp_id  output  2  requester id of the result.
REQ-016 rsp_moves  output  4  result {Left, Down, Up, Right}.
REQ-017 busy  output  1  high while a query is in flight (FETCH or RESP).

Function
REQ-018 FSM states: IDLE, FETCH, RESP.
REQ-019 IDLE with any req high: select a requester round-robin, starting at (last served id + 1) mod NUM_REQ.
REQ-020 On selection: pulse the matching gnt bit, latch that requester's x/y index and id, clear the phase counter, and go to FETCH.
REQ-021 FETCH issue cycles: mem_en=1 at counter 0, 1, 2, with mem_addr = y-1, y, y+1 respectively.
REQ-022 Row-address edge cases: y=0 issues address 0 at counter 0; y=MAP_ROWS-1 issues address y at counter 2.
REQ-023 mem_en=0 at every other counter value.
REQ-024 FETCH capture at counter k+READ_LAT, k=0..2, into 1-bit registers only: above[x] (k=0); same[x-1] and same[x+1] (k=1); below[x] (k=2).
REQ-025 After the capture at counter 2+READ_LAT: go to RESP.
REQ-026 RESP: rsp_valid=1, rsp_id = latched id, rsp_moves = {L, D, U, R} for exactly one cycle.
REQ-027 Move rules: R = 1 if x=MAP_COLS-1 (tunnel), else same[x+1]; L = 1 if x=0 (tunnel), else same[x-1].
REQ-028 Move rules: U = 0 if y=0, else above[x]; D = 0 if y=MAP_ROWS-1, else below[x].
REQ-029 Out-of-range index (x>=MAP_COLS or y>=MAP_ROWS): rsp_moves=4'b0000; the query still completes with normal timing.
REQ-030 RESP also arbitrates, with the id being responded masked out.
REQ-031 RESP with an eligible request: gnt pulse, then FETCH next cycle; otherwise go to IDLE.
REQ-032 Timing: gnt at cycle T gives rsp_valid at T+4+READ_LAT; back-to-back query period is 4+READ_LAT cycles.
REQ-033 Handshake: a requester holds req and its indices stable from assertion until it sees rsp_valid with its id.
REQ-034 A req dropped before gnt is not served; index changes after gnt do not affect the in-flight query.
REQ-035 gnt, rsp_valid and mem_en are never asserted in the same cycle as rst.
REQ-036 rsp_moves and rsp_id hold their last value when rsp_valid=0.

Reset
REQ-037 rst high in any state, including mid-FETCH: next state IDLE; the in-flight query is discarded with no rsp_valid.
REQ-038 Reset values: gnt=0, mem_en=0, mem_addr=0, rsp_valid=0, rsp_id=0, rsp_moves=0, busy=0.
REQ-039 Reset values of internal state: round-robin pointer = id 0 first, phase counter = 0.

Structure
REQ-040 The shared map package holds MAP_COLS, MAP_ROWS, the index widths (7, 6), the move bit positions (RIGHT=0, UP=1, DOWN=2, LEFT=3) and the FSM state encoding.
REQ-041 One sub-module, rr_arbiter (NUM_REQ requests, mask input, pointer update on accept), is instantiated once.
REQ-042 The map memory is external to this block; this block owns its only read port.

Verification
REQ-043 Single query, READ_LAT=1: req[0] at x=10, y=5; row4[10]=1, row5[9]=0, row5[11]=1, row6[10]=0 -> gnt[0] at T; addresses 4, 5, 6 at T+1..T+3; rsp_valid at T+5 with id=0, moves=4'b0011.
REQ-044 Tunnel: x=0, y=5, row5[1]=0 -> L=1, R=0. Repeat with x=79, row5[78]=0 -> R=1, L=0.
REQ-045 Row edges: y=0 with row0[x]=1 and row1[x]=1 -> U=0, D=1. y=59 with row58[x]=1 -> U=1, D=0.
REQ-046 Contention: req=4'b1111 held, each requester dropping on its own response -> grants in order 0, 1, 2, 3, one every 5 cycles, with no requester starved.
REQ-047 Reset mid-FETCH: assert rst at counter 1 -> no rsp_valid; all outputs at reset values; the next request is granted to id 0 first.
REQ-048 Self-mask: only req[2] high and held through RESP -> no regrant in the RESP cycle; re-grant occurs from IDLE one cycle later.
